fifo_enq_arbiter: RTL and testbench
===================================

Name: fifo_enq_arbiter

Overview:
Round-robin arbiter that shares the enqueue port of one FIFO among NREQ requesters, all in the enqueue clock domain. It grants one requester at a time for a bounded burst of up to MAXBURST words, applies FIFO backpressure (full) and rotates priority after each burst. It sits directly in front of the FIFO's enqueue/data_in/full ports.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, data word width; matches the FIFO's WIDTH
MAXBURST, 4, maximum words per grant (>=1)

Ports:
clock  in  1  enqueue-domain clock
reset_n  in  1  synchronous, active-low reset
req  in  NREQ  per-requester "word valid"; held until accepted
req_data  in  NREQ*WIDTH  flattened words; requester i occupies bits [i*WIDTH +: WIDTH]
grant  out  NREQ  one-hot current owner; all-zero when idle
accept  out  NREQ  one-hot; the owner's word is consumed this cycle
fifo_full  in  1  FIFO full flag
fifo_enqueue  out  1  FIFO enqueue strobe
fifo_data  out  WIDTH  FIFO data_in
busy  out  1  high while in GRANT

Behaviour:
- Clock and reset: one clock (clock). reset_n is synchronous and active-low.
- Reset values (reset_n=0 at a clock edge): state=IDLE, grant=0, beat count=0, last_owner=NREQ-1 so requester 0 has first priority. Outputs busy=0, accept=0, fifo_enqueue=0, fifo_data=0.
- Reset mid-burst: state drops to IDLE on that edge. No enqueue occurs in the reset cycle, because fifo_enqueue is gated by reset_n.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req bit is set, pick the first set bit searching from (last_owner+1) mod NREQ upward with wrap-around.
  - Register that index as owner, set grant=onehot(owner), clear count and go to GRANT.
  - Arbitration latency is one cycle: no enqueue occurs in IDLE.
- GRANT, enqueue rule:
  - fifo_enqueue = req[owner] & ~fifo_full. This path is combinational from req and fifo_full.
  - fifo_data = req_data slice of owner. It is combinational and always driven with the owner's slice while in GRANT, and 0 in IDLE.
  - accept = grant & {NREQ{fifo_enqueue}}.
  - A word transfers exactly on a cycle where req[owner] and accept[owner] are both high. The requester presents its next word, or drops req, on the following cycle.
- GRANT, count: count increments on each enqueue. Its width is clog2(MAXBURST+1).
- GRANT, exit conditions. Go to IDLE, set last_owner=owner and clear grant when either holds:
  - req[owner]=0 in a cycle (owner released; no enqueue that cycle), or
  - an enqueue occurs with count==MAXBURST-1 (burst exhausted; the last word is accepted on the exit cycle).
- GRANT, backpressure: while fifo_full=1 and req[owner]=1, hold state. There is no enqueue and count is unchanged. A full FIFO never ends a burst.
- Non-owner req bits are ignored in GRANT. Their req and data must be held stable.
- A requester that exhausts MAXBURST and still requests gets lowest priority in the next arbitration, so it is re-granted only if no other requester is active.
- Simultaneous release and full (req[owner]=0 with fifo_full=1): release wins and the FSM goes to IDLE.
- Throughput: a burst of k words costs k+1 cycles (IDLE arbitration plus k beats) when the FIFO is not full.
- busy = (state==GRANT).
- Assertions: grant and accept are one-hot or zero; accept implies !fifo_full; fifo_enqueue never fires in IDLE.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - a clog2 constant function;
  - localparams for owner width (clog2(NREQ)) and count width (clog2(MAXBURST+1)).
- Sub-module rr_picker: purely combinational round-robin search.
  - Inputs: req[NREQ], last_owner.
  - Outputs: found, index.
  - It is reusable by the dequeue-side scheduler.
- The FSM, counter and output muxing live in fifo_enq_arbiter.

Test Plan:
- Single requester, NREQ=4, MAXBURST=4: req[1] held for 6 words, fifo_full=0.
  - grant=4'b0010 for 4 accepts, then one IDLE cycle, then regrant to 1 for the remaining 2 words.
  - fifo_data sequence equals requester 1's words in order.
- Round-robin contention: req=4'b1011 continuously, MAXBURST=2.
  - Grant order 0,1,3,0,1,3; each burst is exactly 2 accepts.
  - No accept ever appears on requester 2.
- Backpressure: fifo_full=1 for 3 cycles in the middle of a 4-word burst.
  - fifo_enqueue=0 and accept=0 during the stall; grant is held and count is frozen.
  - The burst resumes and completes with exactly 4 words total.
- Early release: owner 2 drops req after 1 word while req[3]=1.
  - Next cycle is IDLE, then grant=4'b1000.
  - last_owner=2 is verified by requester 3 winning over requester 0.
- Reset mid-burst: reset_n=0 for one cycle after 2 beats.
  - grant=0 and busy=0 the next cycle, with no enqueue in the reset cycle.
  - The next arbitration, with all req set, grants requester 0.
- Release coinciding with full: req[owner]=0 with fifo_full=1 in the same cycle.
  - FSM goes to IDLE with no enqueue; the next arbitration proceeds normally.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared types and sizing helpers for the FIFO enqueue arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2, floored at 1 so that derived vectors never collapse to zero width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NREQ_DEF     = 4;
  localparam int MAXBURST_DEF = 4;
  localparam int OWNER_W      = clog2(NREQ_DEF);
  localparam int CNT_W        = clog2(MAXBURST_DEF + 1);

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin search starting just after the last owner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_owner,
  output logic            o_found,
  output logic [IW-1:0]   o_index
);

  int w_cand;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    o_found = |i_req;
    o_index = '0;
    w_cand  = 0;
    for (int off = NREQ; off >= 1; off--) begin
      w_cand = (int'(i_last_owner) + off) % NREQ;
      if (i_req[IW'(w_cand)]) o_index = IW'(w_cand);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_enq_arbiter
// Brief    : Round-robin, burst-limited sharing of one FIFO enqueue port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       accept,
  input  logic                  fifo_full,
  output logic                  fifo_enqueue,
  output logic [WIDTH-1:0]      fifo_data,
  output logic                  busy
);

  localparam int OW = clog2(NREQ);
  localparam int CW = clog2(MAXBURST + 1);

  arb_state_t      r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last_owner;
  logic [NREQ-1:0] r_grant;
  logic [CW-1:0]   r_count;

  logic            w_found;
  logic [OW-1:0]   w_pick_idx;
  logic            w_in_grant;
  logic            w_owner_req;
  logic            w_enq;
  logic [WIDTH-1:0] w_words [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_words[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_picker #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_picker (
    .i_req        (req),
    .i_last_owner (r_last_owner),
    .o_found      (w_found),
    .o_index      (w_pick_idx)
  );

  assign w_in_grant  = (r_state == GRANT);
  assign w_owner_req = req[r_owner];
  // Gated by reset_n so a reset edge mid-burst never commits a word.
  assign w_enq       = reset_n & w_in_grant & w_owner_req & ~fifo_full;

  assign fifo_enqueue = w_enq;
  assign fifo_data    = w_in_grant ? w_words[r_owner] : '0;
  assign grant        = r_grant;
  assign accept       = r_grant & {NREQ{w_enq}};
  assign busy         = w_in_grant;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NREQ - 1);
      r_grant      <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick_idx;
            r_grant <= NREQ'(1) << w_pick_idx;
            r_count <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          // Release takes priority over backpressure; a full FIFO only stalls.
          if (!w_owner_req) begin
            r_state      <= IDLE;
            r_last_owner <= r_owner;
            r_grant      <= '0;
          end else if (w_enq) begin
            if (r_count == CW'(MAXBURST - 1)) begin
              r_state      <= IDLE;
              r_last_owner <= r_owner;
              r_grant      <= '0;
              r_count      <= '0;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert ($onehot0(grant));
      assert ($onehot0(accept));
      assert (!(|accept) || !fifo_full);
      assert (!fifo_enqueue || w_in_grant);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_enq_arbiter
// Brief    : Cycle-by-cycle vector bench for the FIFO enqueue arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_enq_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  grant, accept;
  logic        fifo_enqueue, busy;
  logic [7:0]  fifo_data;

  logic [3:0]  req2;
  logic [31:0] req_data2;
  logic        fifo_full2;
  logic [3:0]  grant2, accept2;
  logic        fifo_enqueue2, busy2;
  logic [7:0]  fifo_data2;

  int total;
  int bad;

  fifo_enq_arbiter #(.NREQ(4), .WIDTH(8), .MAXBURST(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .accept       (accept),
    .fifo_full    (fifo_full),
    .fifo_enqueue (fifo_enqueue),
    .fifo_data    (fifo_data),
    .busy         (busy)
  );

  fifo_enq_arbiter #(.NREQ(4), .WIDTH(8), .MAXBURST(2)) dut2 (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req2),
    .req_data     (req_data2),
    .grant        (grant2),
    .accept       (accept2),
    .fifo_full    (fifo_full2),
    .fifo_enqueue (fifo_enqueue2),
    .fifo_data    (fifo_data2),
    .busy         (busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic        full;
    logic [31:0] data;
    logic [3:0]  eg;
    logic [3:0]  ea;
    logic        ee;
    logic        eb;
    logic [7:0]  efd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstn, input logic [3:0] r, input logic f,
                     input logic [7:0] d3, input logic [7:0] d2,
                     input logic [7:0] d1, input logic [7:0] d0,
                     input logic [3:0] eg, input logic [3:0] ea,
                     input logic ee, input logic eb, input logic [7:0] efd);
    vec_t v;
    v.rstn = rstn; v.req = r; v.full = f; v.data = {d3, d2, d1, d0};
    v.eg = eg; v.ea = ea; v.ee = ee; v.eb = eb; v.efd = efd;
    vecs.push_back(v);
  endtask

  initial begin
    logic [17:0] got, exp;
    int          ord [6];
    total = 0;
    bad   = 0;
    reset_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
    req2 = '0; req_data2 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; fifo_full2 = 1'b0;

    //   rstn req     full d3     d2     d1     d0     grant   accept  enq  busy fdata
    // reset state, then requester 1 alone for six words (4 + 2 after re-arbitration)
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h11);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h12, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h12);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h13, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h13);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h14, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h14);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h15, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h15, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h15);
    add(1, 4'b0010, 0, 8'h00, 8'h00, 8'h16, 8'h00, 4'b0010, 4'b0010, 1, 1, 8'h16);
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h16, 8'h00, 4'b0010, 4'b0000, 0, 1, 8'h16);
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    // backpressure: three full cycles in the middle of requester 0's burst
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h01, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h01, 4'b0001, 4'b0001, 1, 1, 8'h01);
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h02, 4'b0001, 4'b0001, 1, 1, 8'h02);
    add(1, 4'b0001, 1, 8'h00, 8'h00, 8'h00, 8'h03, 4'b0001, 4'b0000, 0, 1, 8'h03);
    add(1, 4'b0001, 1, 8'h00, 8'h00, 8'h00, 8'h03, 4'b0001, 4'b0000, 0, 1, 8'h03);
    add(1, 4'b0001, 1, 8'h00, 8'h00, 8'h00, 8'h03, 4'b0001, 4'b0000, 0, 1, 8'h03);
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h03, 4'b0001, 4'b0001, 1, 1, 8'h03);
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h04, 4'b0001, 4'b0001, 1, 1, 8'h04);
    add(1, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h05, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h05, 4'b0001, 4'b0000, 0, 1, 8'h05);
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    // early release by owner 2; requester 3 must then beat requester 0
    add(1, 4'b0100, 0, 8'h00, 8'h21, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b1100, 0, 8'h31, 8'h21, 8'h00, 8'h06, 4'b0100, 4'b0100, 1, 1, 8'h21);
    add(1, 4'b1001, 0, 8'h31, 8'h21, 8'h00, 8'h06, 4'b0100, 4'b0000, 0, 1, 8'h21);
    add(1, 4'b1001, 0, 8'h31, 8'h21, 8'h00, 8'h06, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b1001, 0, 8'h31, 8'h21, 8'h00, 8'h06, 4'b1000, 4'b1000, 1, 1, 8'h31);
    add(1, 4'b1001, 0, 8'h32, 8'h21, 8'h00, 8'h06, 4'b1000, 4'b1000, 1, 1, 8'h32);
    // reset mid-burst, then all requesting: requester 0 first
    add(0, 4'b1001, 0, 8'h33, 8'h21, 8'h00, 8'h06, 4'b1000, 4'b0000, 0, 1, 8'h33);
    add(1, 4'b1111, 0, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b1111, 0, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0001, 4'b0001, 1, 1, 8'h07);
    // release coinciding with full
    add(1, 4'b1110, 1, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0001, 4'b0000, 0, 1, 8'h07);
    add(1, 4'b1110, 0, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0000, 4'b0000, 0, 0, 8'h00);
    add(1, 4'b1110, 0, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0010, 4'b0010, 1, 1, 8'h17);
    add(1, 4'b0000, 0, 8'h37, 8'h27, 8'h17, 8'h07, 4'b0010, 4'b0000, 0, 1, 8'h17);
    add(1, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00);

    repeat (2) @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      reset_n   = vecs[i].rstn;
      req       = vecs[i].req;
      fifo_full = vecs[i].full;
      req_data  = vecs[i].data;
      @(negedge clock);
      got = {grant, accept, fifo_enqueue, busy, fifo_data};
      exp = {vecs[i].eg, vecs[i].ea, vecs[i].ee, vecs[i].eb, vecs[i].efd};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL vec%0d {grant,accept,enq,busy,data}: got %h expected %h", i, got, exp);
      end
      @(posedge clock);
      #1;
    end

    // MAXBURST=2 contention with requesters 0,1,3 permanently active
    ord[0] = 0; ord[1] = 1; ord[2] = 3; ord[3] = 0; ord[4] = 1; ord[5] = 3;
    req2 = 4'b1011;
    for (int k = 0; k < 18; k++) begin
      logic [11:0] got2, exp2;
      @(negedge clock);
      if (k % 3 == 0) exp2 = 12'h000;
      else exp2 = {4'(1 << ord[k/3]), 8'(8'hA0 + ord[k/3])};
      got2 = {accept2, fifo_data2};
      total++;
      if (got2 !== exp2) begin
        bad++;
        $display("FAIL rr_cycle%0d {accept,data}: got %h expected %h", k, got2, exp2);
      end
      @(posedge clock);
      #1;
    end
    req2 = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
